// File: rtl/opc_pkg.sv
// Shared definitions for the OPC system controller slice.
// Holds the default address/data widths used by the CPU and its memory,
// the run-cycle counter width, the host command opcodes and the
// controller state encoding.
package opc_pkg;

  localparam int OPC_AW = 12;
  localparam int OPC_DW = 8;
  localparam int OPC_CW = 16;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_DUMP = 2'd1;
  localparam logic [1:0] OP_RUN  = 2'd2;
  localparam logic [1:0] OP_NOP  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_DUMP_FETCH = 3'd2,
    ST_DUMP_SEND  = 3'd3,
    ST_RUN        = 3'd4
  } state_e;

endpackage

// File: rtl/opc_boot_ctrl_if.sv
// Host-side interface of the OPC system controller.
// Groups the command channel (cmd_*), the LOAD byte stream (wr_*), the
// DUMP byte stream (rd_*), the RUN abort (stop) and the status outputs
// (busy, done, run_count).
//   master : the host (drives commands, load bytes, rd_ready, stop)
//   slave  : the controller
interface opc_boot_ctrl_if import opc_pkg::*; #(
  parameter int AW = OPC_AW,
  parameter int DW = OPC_DW,
  parameter int CW = OPC_CW
) ();

  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic [CW-1:0] cmd_cycles;
  logic          stop;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic [CW-1:0] run_count;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_cycles, stop,
           wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, run_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_cycles, stop,
           wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, run_count
  );

endinterface

// File: rtl/opc_mem_mux.sv
// Combinational select of the single memory port between the CPU and the
// host path.
//   cpu_sel                          : 1 = CPU owns memory (RUN)
//   cpu_address/cpu_wdata/cpu_rnw    : CPU bus
//   host_addr/host_wdata/host_we     : host path from the controller
//   mem_addr/mem_wdata/mem_we        : memory port
module opc_mem_mux import opc_pkg::*; #(
  parameter int AW = OPC_AW,
  parameter int DW = OPC_DW
) (
  input  logic          cpu_sel,
  input  logic [AW-1:0] cpu_address,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_rnw,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic          host_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we
);

  // Port select: CPU bus in RUN, host path otherwise.
  always_comb begin
    mem_addr  = host_addr;
    mem_wdata = host_wdata;
    mem_we    = 1'b0;
    if (cpu_sel) begin
      mem_addr  = cpu_address;
      mem_wdata = cpu_wdata;
      mem_we    = ~cpu_rnw;
    end else begin
      mem_we    = host_we;
    end
  end

endmodule

// File: rtl/opc_boot_ctrl.sv
// OPC system controller: owns the memory port and the CPU reset line.
// Host commands LOAD memory, DUMP memory, or RUN the CPU for a bounded
// (cmd_cycles != 0) or host-stopped number of clocks.
//   clk, reset_b                     : clock, async active-low reset
//   host (opc_boot_ctrl_if.slave)    : command / load / dump / status
//   cpu_reset_b                      : registered CPU reset, low outside RUN
//   cpu_address/cpu_wdata/cpu_rnw    : CPU bus in
//   cpu_rdata                        : memory read data to CPU
//   mem_addr/mem_wdata/mem_we        : memory port (write on posedge)
//   mem_rdata                        : combinational memory read data
module opc_boot_ctrl import opc_pkg::*; #(
  parameter int AW = OPC_AW,
  parameter int DW = OPC_DW,
  parameter int CW = OPC_CW
) (
  input  logic             clk,
  input  logic             reset_b,
  opc_boot_ctrl_if.slave   host,
  output logic             cpu_reset_b,
  input  logic [AW-1:0]    cpu_address,
  input  logic [DW-1:0]    cpu_wdata,
  input  logic             cpu_rnw,
  output logic [DW-1:0]    cpu_rdata,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  output logic             mem_we,
  input  logic [DW-1:0]    mem_rdata
);

  localparam logic [AW-1:0] A_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] A_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] C_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] C_ONE  = {{(CW-1){1'b0}}, 1'b1};

  state_e        state_r, state_s;
  logic [AW-1:0] ptr_r, rem_r;
  logic [CW-1:0] cycles_r, cnt_r, run_count_r;
  logic          cpu_reset_b_r, done_r, done_s;
  logic [DW-1:0] rd_data_r;

  logic          cmd_take_s, wr_beat_s, rd_take_s, run_exit_s;
  logic [CW-1:0] cnt_inc_s;

  assign cmd_take_s = (state_r == ST_IDLE) & host.cmd_valid;
  assign wr_beat_s  = (state_r == ST_LOAD) & host.wr_valid;
  assign rd_take_s  = (state_r == ST_DUMP_SEND) & host.rd_ready;
  assign cnt_inc_s  = cnt_r + C_ONE;
  // Exit decision uses the post-increment count so that exactly cmd_cycles
  // edges see cpu_reset_b high; stop and budget together give one exit.
  assign run_exit_s = (state_r == ST_RUN) &
                      (host.stop | ((cycles_r != C_ZERO) & (cnt_inc_s == cycles_r)));

  // State register.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and completion decode.
  always_comb begin
    state_s = state_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_take_s) begin
          case (host.cmd_op)
            OP_LOAD: state_s = ST_LOAD;
            OP_DUMP: state_s = ST_DUMP_FETCH;
            OP_RUN:  state_s = ST_RUN;
            default: begin
              state_s = ST_IDLE;
              done_s  = 1'b1;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (wr_beat_s && (rem_r == A_ZERO)) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_DUMP_FETCH: state_s = ST_DUMP_SEND;
      ST_DUMP_SEND: begin
        if (rd_take_s) begin
          if (rem_r == A_ZERO) begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = ST_DUMP_FETCH;
          end
        end else begin
          state_s = ST_DUMP_SEND;
        end
      end
      ST_RUN: begin
        if (run_exit_s) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Pointer, counters, CPU reset, dump byte and status registers.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      ptr_r         <= A_ZERO;
      rem_r         <= A_ZERO;
      cycles_r      <= C_ZERO;
      cnt_r         <= C_ZERO;
      run_count_r   <= C_ZERO;
      cpu_reset_b_r <= 1'b0;
      done_r        <= 1'b0;
      rd_data_r     <= {DW{1'b0}};
    end else begin
      done_r <= done_s;
      case (state_r)
        ST_IDLE: begin
          if (cmd_take_s) begin
            ptr_r    <= host.cmd_addr;
            rem_r    <= host.cmd_len;
            cycles_r <= host.cmd_cycles;
            cnt_r    <= C_ZERO;
            if (host.cmd_op == OP_RUN) begin
              cpu_reset_b_r <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (wr_beat_s) begin
            ptr_r <= ptr_r + A_ONE;
            rem_r <= rem_r - A_ONE;
          end
        end
        ST_DUMP_FETCH: begin
          rd_data_r <= mem_rdata;
          ptr_r     <= ptr_r + A_ONE;
        end
        ST_DUMP_SEND: begin
          if (rd_take_s) begin
            rem_r <= rem_r - A_ONE;
          end
        end
        ST_RUN: begin
          cnt_r <= cnt_inc_s;
          if (run_exit_s) begin
            cpu_reset_b_r <= 1'b0;
            run_count_r   <= cnt_inc_s;
          end
        end
        default: begin
          cpu_reset_b_r <= 1'b0;
        end
      endcase
    end
  end

  assign host.cmd_ready = (state_r == ST_IDLE);
  assign host.busy      = (state_r != ST_IDLE);
  assign host.wr_ready  = (state_r == ST_LOAD);
  assign host.rd_valid  = (state_r == ST_DUMP_SEND);
  assign host.rd_data   = rd_data_r;
  assign host.done      = done_r;
  assign host.run_count = run_count_r;
  assign cpu_reset_b    = cpu_reset_b_r;
  assign cpu_rdata      = mem_rdata;

  opc_mem_mux #(.AW(AW), .DW(DW)) u_mux (
    .cpu_sel     (state_r == ST_RUN),
    .cpu_address (cpu_address),
    .cpu_wdata   (cpu_wdata),
    .cpu_rnw     (cpu_rnw),
    .host_addr   (ptr_r),
    .host_wdata  (host.wr_data),
    .host_we     (wr_beat_s),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we)
  );

endmodule

// File: tb/tb_opc_boot_ctrl.sv
// Scoreboard bench for opc_boot_ctrl: directed scenarios followed by random
// commands. Expected memory writes, dump bytes and completions are queued
// when stimulus is issued; a negedge monitor pops and compares them.
module tb_opc_boot_ctrl;
  import opc_pkg::*;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  always #5 clk = ~clk;

  opc_boot_ctrl_if #(.AW(AW), .DW(DW), .CW(CW)) host ();

  logic          cpu_reset_b;
  logic [AW-1:0] cpu_address;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_rnw;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  opc_boot_ctrl #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .reset_b(reset_b), .host(host),
    .cpu_reset_b(cpu_reset_b), .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
    .cpu_rnw(cpu_rnw), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 7 + 3) ^ (i >> 5));
  endfunction

  // Memory: synchronous write, combinational read.
  logic [7:0] mem [0:4095];
  logic mem_init = 1'b1;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_byte(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  // Reference model and scoreboard.
  logic [7:0] ref_mem [0:4095];
  typedef struct { logic [11:0] a; logic [7:0] d; } wr_t;
  typedef struct { bit is_run; int rc; } done_t;
  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  done_t      exp_done[$];
  int checks = 0;
  int errors = 0;
  int hi_cnt = 0;
  logic [7:0] lb [0:15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  // Monitor: compares every DUT output event against the queues.
  always @(negedge clk) begin
    if (reset_b) begin
      if (cpu_reset_b) begin
        hi_cnt++;
        check("mux_addr", 64'(mem_addr), 64'(cpu_address));
        check("mux_we", 64'(mem_we), 64'(!cpu_rnw));
      end else if (mem_we) begin
        if (exp_wr.size() == 0) begin
          fail_evt("host_wr_unexpected");
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("wr_addr", 64'(mem_addr), 64'(w.a));
          check("wr_data", 64'(mem_wdata), 64'(w.d));
        end
      end
      if (host.rd_valid) begin
        if (exp_rd.size() == 0) begin
          fail_evt("rd_unexpected");
        end else if (host.rd_ready) begin
          logic [7:0] e;
          e = exp_rd.pop_front();
          check("rd_data", 64'(host.rd_data), 64'(e));
        end else begin
          check("rd_stable", 64'(host.rd_data), 64'(exp_rd[0]));
        end
      end
      if (host.done) begin
        if (exp_done.size() == 0) begin
          fail_evt("done_unexpected");
        end else begin
          done_t dn;
          dn = exp_done.pop_front();
          check("done_busy", 64'(host.busy), 64'd0);
          if (dn.is_run) begin
            check("run_count", 64'(host.run_count), 64'(dn.rc));
            check("cpu_high_clocks", 64'(hi_cnt), 64'(dn.rc));
          end
        end
        hi_cnt = 0;
      end
    end
  end

  // CPU stand-in: random reads; on its third clock in each run it stores one
  // byte (the first run stores 0x5A to 0x100, like the loaded program).
  initial begin
    int stub_c;
    int run_idx;
    stub_c = 0;
    run_idx = 0;
    cpu_rnw = 1'b1;
    cpu_address = 12'h000;
    cpu_wdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (cpu_reset_b === 1'b1) begin
        if (stub_c == 2) begin
          cpu_address = 12'h100 + 12'(run_idx % 16);
          cpu_wdata = (run_idx == 0) ? 8'h5A : 8'($urandom);
          cpu_rnw = 1'b0;
          ref_mem[cpu_address] = cpu_wdata;
        end else begin
          cpu_address = 12'($urandom);
          cpu_wdata = 8'($urandom);
          cpu_rnw = 1'b1;
        end
        stub_c++;
      end else begin
        if (stub_c != 0) run_idx++;
        stub_c = 0;
        cpu_rnw = 1'b1;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!host.cmd_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!host.cmd_ready) fail_evt("idle_timeout");
  endtask

  task automatic issue(input logic [1:0] op, input logic [11:0] a, input logic [11:0] len,
                       input logic [15:0] cyc);
    wait_idle();
    host.cmd_op = op;
    host.cmd_addr = a;
    host.cmd_len = len;
    host.cmd_cycles = cyc;
    host.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    host.cmd_valid = 1'b0;
    host.cmd_op = 2'($urandom);
  endtask

  task automatic do_load(input logic [11:0] a, input int len);
    exp_done.push_back('{is_run: 1'b0, rc: 0});
    issue(OP_LOAD, a, 12'(len), 16'd0);
    for (int i = 0; i <= len; i++) begin
      logic [11:0] wa;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      wa = a + 12'(i);
      host.wr_data = lb[i];
      host.wr_valid = 1'b1;
      exp_wr.push_back('{a: wa, d: lb[i]});
      ref_mem[wa] = lb[i];
      @(posedge clk);
      #1;
      host.wr_valid = 1'b0;
    end
  endtask

  task automatic do_dump(input logic [11:0] a, input int len, input int hold);
    exp_done.push_back('{is_run: 1'b0, rc: 0});
    for (int i = 0; i <= len; i++) exp_rd.push_back(ref_mem[a + 12'(i)]);
    issue(OP_DUMP, a, 12'(len), 16'd0);
    for (int i = 0; i <= len; i++) begin
      int n;
      int h;
      n = 0;
      while (!host.rd_valid && n < 20) begin @(posedge clk); #1; n++; end
      if (!host.rd_valid) begin
        fail_evt("rd_valid_timeout");
        return;
      end
      h = (hold < 0) ? $urandom_range(0, 3) : hold;
      repeat (h) begin @(posedge clk); #1; end
      host.rd_ready = 1'b1;
      @(posedge clk);
      #1;
      host.rd_ready = 1'b0;
    end
    wait_idle();
    check("dump_all_bytes", 64'(exp_rd.size()), 64'd0);
  endtask

  // cyc = budget (0 = unbounded); s = clock on which stop is sampled (0 = none).
  task automatic do_run(input int cyc, input int s);
    int rc;
    rc = (cyc != 0 && (s == 0 || cyc <= s)) ? cyc : s;
    exp_done.push_back('{is_run: 1'b1, rc: rc});
    issue(OP_RUN, 12'h000, 12'h000, 16'(cyc));
    if (s != 0) begin
      repeat (s - 1) begin @(posedge clk); #1; end
      host.stop = 1'b1;
      @(posedge clk);
      #1;
      host.stop = 1'b0;
    end
    wait_idle();
    check("run_cpu_reset_low", 64'(cpu_reset_b), 64'd0);
  endtask

  initial begin
    logic [7:0] prog [0:5];
    prog[0] = 8'h90; prog[1] = 8'h5A; prog[2] = 8'h21;
    prog[3] = 8'h00; prog[4] = 8'h70; prog[5] = 8'h04;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);
    host.cmd_valid = 1'b0; host.cmd_op = 2'd0; host.cmd_addr = 12'h000;
    host.cmd_len = 12'h000; host.cmd_cycles = 16'd0; host.stop = 1'b0;
    host.wr_valid = 1'b0; host.wr_data = 8'h00; host.rd_ready = 1'b0;

    // Reset state.
    repeat (3) begin @(posedge clk); #1; end
    mem_init = 1'b0;
    check("rst_cmd_ready", 64'(host.cmd_ready), 64'd1);
    check("rst_cpu_reset_b", 64'(cpu_reset_b), 64'd0);
    check("rst_wr_ready", 64'(host.wr_ready), 64'd0);
    check("rst_rd_valid", 64'(host.rd_valid), 64'd0);
    check("rst_rd_data", 64'(host.rd_data), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_busy", 64'(host.busy), 64'd0);
    check("rst_done", 64'(host.done), 64'd0);
    check("rst_run_count", 64'(host.run_count), 64'd0);
    reset_b = 1'b1;
    @(posedge clk);
    #1;

    // Program load, run, and readback of the stored byte.
    for (int i = 0; i < 6; i++) lb[i] = prog[i];
    do_load(12'h000, 5);
    do_run(40, 0);
    do_dump(12'h100, 0, 0);

    // Address wrap on load and dump.
    lb[0] = 8'h11; lb[1] = 8'h22; lb[2] = 8'h33; lb[3] = 8'h44;
    do_load(12'hFFE, 3);
    do_dump(12'hFFE, 3, 0);

    // Backpressure: 3 bytes, rd_ready low 5 cycles each.
    do_dump(12'hFFF, 2, 5);

    // Unbounded run stopped after 17 clocks; stop and budget coinciding.
    do_run(0, 17);
    do_run(20, 20);

    // Reserved opcode.
    exp_done.push_back('{is_run: 1'b0, rc: 0});
    issue(OP_NOP, 12'h000, 12'h000, 16'd0);
    @(posedge clk);
    #1;

    // Reset during a LOAD after 2 of 4 bytes.
    issue(OP_LOAD, 12'h200, 12'd3, 16'd0);
    for (int i = 0; i < 2; i++) begin
      logic [7:0] d;
      d = 8'hC0 + 8'(i);
      host.wr_data = d;
      host.wr_valid = 1'b1;
      exp_wr.push_back('{a: 12'h200 + 12'(i), d: d});
      ref_mem[12'h200 + 12'(i)] = d;
      @(posedge clk);
      #1;
    end
    reset_b = 1'b0;
    host.wr_data = 8'hEE;
    #1;
    check("abort_cmd_ready", 64'(host.cmd_ready), 64'd1);
    check("abort_cpu_reset_b", 64'(cpu_reset_b), 64'd0);
    check("abort_busy", 64'(host.busy), 64'd0);
    check("abort_wr_ready", 64'(host.wr_ready), 64'd0);
    @(posedge clk);
    #1;
    reset_b = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    host.wr_valid = 1'b0;
    do_dump(12'h200, 3, 0);

    // Random commands, with idle-time noise on wr_valid/stop/rd_ready.
    for (int k = 0; k < 40; k++) begin
      int op;
      int len;
      int cyc;
      int s;
      logic [11:0] a;
      op = $urandom_range(0, 3);
      a = 12'($urandom);
      len = $urandom_range(0, 6);
      case (op)
        0: begin
          for (int i = 0; i < 16; i++) lb[i] = 8'($urandom);
          do_load(a, len);
        end
        1: do_dump(a, len, -1);
        2: begin
          cyc = $urandom_range(0, 30);
          if (cyc == 0) s = $urandom_range(1, 30);
          else if ($urandom_range(0, 1) == 0) s = 0;
          else s = $urandom_range(1, 35);
          do_run(cyc, s);
        end
        default: begin
          exp_done.push_back('{is_run: 1'b0, rc: 0});
          issue(OP_NOP, a, 12'(len), 16'd0);
          @(posedge clk);
          #1;
        end
      endcase
      wait_idle();
      if ($urandom_range(0, 3) == 0) begin
        host.wr_valid = 1'b1;
        host.wr_data = 8'($urandom);
        host.stop = 1'b1;
        host.rd_ready = 1'b1;
        @(posedge clk);
        #1;
        host.wr_valid = 1'b0;
        host.stop = 1'b0;
        host.rd_ready = 1'b0;
      end
    end

    wait_idle();
    repeat (5) begin @(posedge clk); #1; end
    check("left_wr", 64'(exp_wr.size()), 64'd0);
    check("left_rd", 64'(exp_rd.size()), 64'd0);
    check("left_done", 64'(exp_done.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/opc_boot_ctrl.md
Name: opc_boot_ctrl

Overview:
System controller for the OPC 8-bit accumulator CPU and its 4 KB memory. It owns the single memory port and the CPU reset line. A host command interface can load memory, dump memory, and run the CPU for a bounded or host-stopped number of cycles. In all non-RUN states the CPU is held in reset and the host owns memory; in RUN the CPU owns memory.

Parameters:
AW, 12, address width (memory depth 2^AW bytes)
DW, 8, data width
CW, 16, run-cycle counter width

Ports:
clk  in  1  clock
reset_b  in  1  asynchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  0=LOAD, 1=DUMP, 2=RUN, 3=reserved
cmd_addr  in  AW  start address (LOAD/DUMP)
cmd_len  in  AW  byte count minus 1 (LOAD/DUMP)
cmd_cycles  in  CW  RUN budget in clocks; 0 = unbounded
stop  in  1  host abort of RUN
wr_valid/wr_ready  in/out  1  LOAD byte handshake
wr_data  in  DW  LOAD byte
rd_valid/rd_ready  out/in  1  DUMP byte handshake
rd_data  out  DW  DUMP byte
cpu_reset_b  out  1  CPU reset, active low, registered
cpu_address  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_rnw  in  1  CPU read(1)/write(0)
cpu_rdata  out  DW  memory read data to CPU (= mem_rdata)
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_we  out  1  memory write enable (memory writes on posedge; reads combinationally)
mem_rdata  in  DW  memory read data
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at command completion
run_count  out  CW  clocks executed by the last RUN

Behaviour:
- Reset: state IDLE; cpu_reset_b=0, cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=0, mem_we=0, busy=0, done=0, run_count=0. Pointer and counters are cleared.
- States: IDLE, LOAD, DUMP_FETCH, DUMP_SEND, RUN.
- cmd_ready=1 only in IDLE. A command is accepted on cmd_valid&cmd_ready, and its fields are latched on that edge.
- Memory mux: in RUN, mem_addr=cpu_address, mem_wdata=cpu_wdata, mem_we=~cpu_rnw. In other states the host path drives the mux, and mem_we is 0 except in LOAD.
- LOAD:
  - wr_ready=1.
  - A beat on wr_valid&wr_ready drives mem_addr=ptr, mem_wdata=wr_data, mem_we=1 combinationally in that cycle.
  - ptr increments modulo 2^AW (0xFFF→0x000); remaining decrements.
  - The beat with remaining==0 is the last: next state IDLE, done=1 next cycle.
  - No beat means no write and no pointer change.
- DUMP:
  - DUMP_FETCH (1 cycle): rd_data<=mem_rdata at ptr; ptr++ with wrap.
  - DUMP_SEND: rd_valid=1 and rd_data stable until rd_ready. On accept, go to DUMP_FETCH, or to IDLE with done pulse if it was the last byte.
  - Throughput is 1 byte per 2 cycles without backpressure.
- RUN:
  - On accept, cpu_reset_b<=1 on the next edge; run counter cleared.
  - Each clock in RUN with cpu_reset_b=1 increments the counter.
  - Exit when counter==cmd_cycles (cmd_cycles≠0), or when stop=1 is sampled. If both occur in the same cycle, treat it as one exit.
  - On exit: cpu_reset_b<=0, run_count<=counter value, state IDLE, done pulse.
  - cmd_cycles=0 runs until stop.
  - Exactly cmd_cycles clocks elapse with cpu_reset_b high.
- stop is ignored outside RUN. wr_valid is ignored outside LOAD. rd_ready is ignored outside DUMP_SEND.
- cmd_op=3: accepted, no action, done pulses the next cycle.
- Counter overflow in unbounded RUN wraps modulo 2^CW.
- Reset asserted mid-operation aborts immediately: all outputs return to reset values, and the CPU is held in reset. Partial LOAD writes remain in memory.
- done and busy: done rises in the same edge that busy falls.

Decomposition:
- Package opc_pkg holds the cmd_op encodings (OP_LOAD, OP_DUMP, OP_RUN), the state enum, and the AW/DW defaults shared with the CPU.
- One sub-module is natural: opc_mem_mux, a combinational CPU/host memory port select.
- The FSM, pointer and counters stay in opc_boot_ctrl.

Test Plan:
1. LOAD addr 0x000, len 5, bytes 90 5A 21 00 70 04 (LDAI 0x5A; STA 0x100; JP 0x004) → six mem_we pulses at 0x000–0x005; done pulse once; cpu_reset_b stays 0.
2. RUN cycles=40 after test 1 → cpu_reset_b high exactly 40 clocks, run_count=40. A following DUMP addr 0x100 len 0 returns rd_data=0x5A.
3. LOAD addr 0xFFE, len 3, bytes 11 22 33 44 → writes 0xFFE, 0xFFF, 0x000, 0x001. DUMP of the same range returns 11 22 33 44 in order.
4. DUMP len 2 with rd_ready held low 5 cycles per byte → rd_valid held, rd_data stable; exactly 3 bytes delivered; no duplicates.
5. RUN cycles=0 with stop asserted after 17 clocks → cpu_reset_b falls the next edge; run_count=17; done pulses. Also: stop and budget expiry in the same cycle → a single done.
6. reset_b pulsed low during LOAD after 2 of 4 bytes → immediate IDLE, cmd_ready=1, cpu_reset_b=0. The first 2 bytes are written; later wr_valid is ignored.
